// File: rtl/pr_line_fetcher_pkg.sv
// Shared types and default geometry for the PageRank line fetch path.
package pr_pkg;

  localparam int unsigned PR_FULL_WIDTH   = 512;
  localparam int unsigned PR_WIDTH        = 64;
  localparam int unsigned ELEMS_PER_LINE  = PR_FULL_WIDTH / PR_WIDTH;
  localparam int unsigned LOG2_ELEMS      = $clog2(ELEMS_PER_LINE);
  localparam int unsigned LINE_BYTES      = PR_FULL_WIDTH / 8;
  localparam int unsigned LOG2_LINE_BYTES = $clog2(LINE_BYTES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_PRESENT,
    S_FINISH
  } pr_fetch_state_t;

endpackage

// File: rtl/pr_line_fetcher_window.sv
// Per-line element window: which slots of line `cur` fall inside [idx_start, idx_end).
module pr_line_window #(
  parameter int unsigned IDX_WIDTH = 32,
  parameter int unsigned LOG2_E    = pr_pkg::LOG2_ELEMS
) (
  input  logic [IDX_WIDTH-1:0] cur,
  input  logic [IDX_WIDTH-1:0] idx_start,
  input  logic [IDX_WIDTH-1:0] idx_end,
  output logic [7:0]           base,
  output logic [7:0]           bounds,
  output logic                 last
);

  localparam logic [IDX_WIDTH-1:0] SLOT_MASK = IDX_WIDTH'((1 << LOG2_E) - 1);
  localparam logic [7:0]           FULL_LINE = 8'(1 << LOG2_E);

  logic [IDX_WIDTH-1:0] end_m1;
  logic [IDX_WIDTH-1:0] first_line;
  logic [IDX_WIDTH-1:0] last_line;
  logic [IDX_WIDTH-1:0] start_slot;
  logic [IDX_WIDTH-1:0] end_slot;

  always_comb begin
    end_m1     = idx_end - IDX_WIDTH'(1);
    first_line = idx_start >> LOG2_E;
    last_line  = end_m1 >> LOG2_E;
    start_slot = idx_start & SLOT_MASK;
    end_slot   = end_m1 & SLOT_MASK;
    last       = (cur == last_line);
    base       = (cur == first_line) ? 8'(start_slot) : '0;
    bounds     = last ? (8'(end_slot) + 8'd1) : FULL_LINE;
  end

endmodule

// File: rtl/pr_line_fetcher.sv
// Walks an element range line by line, one outstanding read, presenting each line with its slot window.
module pr_line_fetcher
  import pr_pkg::*;
#(
  parameter int unsigned FULL_WIDTH = PR_FULL_WIDTH,
  parameter int unsigned WIDTH      = PR_WIDTH,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned IDX_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_base_addr,
  input  logic [IDX_WIDTH-1:0]  req_start,
  input  logic [IDX_WIDTH-1:0]  req_end,
  output logic                  mem_rd_valid,
  input  logic                  mem_rd_ready,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic                  mem_resp_valid,
  input  logic [FULL_WIDTH-1:0] mem_resp_data,
  output logic                  line_valid,
  input  logic                  buf_ready,
  output logic [FULL_WIDTH-1:0] line_data,
  output logic [7:0]            line_base,
  output logic [7:0]            line_bounds,
  output logic                  line_last,
  output logic                  done
);

  localparam int unsigned L2E  = $clog2(FULL_WIDTH / WIDTH);
  localparam int unsigned L2LB = $clog2(FULL_WIDTH / 8);

  pr_fetch_state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] base_addr_q;
  logic [IDX_WIDTH-1:0]  start_q;
  logic [IDX_WIDTH-1:0]  end_q;
  logic [IDX_WIDTH-1:0]  cur_q;
  logic [FULL_WIDTH-1:0] data_q;
  logic [7:0]            base_q;
  logic [7:0]            bounds_q;
  logic                  last_q;

  logic [7:0]            win_base;
  logic [7:0]            win_bounds;
  logic                  win_last;

  pr_line_window #(
    .IDX_WIDTH (IDX_WIDTH),
    .LOG2_E    (L2E)
  ) u_window (
    .cur       (cur_q),
    .idx_start (start_q),
    .idx_end   (end_q),
    .base      (win_base),
    .bounds    (win_bounds),
    .last      (win_last)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    req_ready    = 1'b0;
    mem_rd_valid = 1'b0;
    line_valid   = 1'b0;
    done         = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = !rst;
        if (req_valid) state_d = (req_start >= req_end) ? S_FINISH : S_ISSUE;
      end
      S_ISSUE: begin
        mem_rd_valid = 1'b1;
        if (mem_rd_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_resp_valid) state_d = S_PRESENT;
      end
      S_PRESENT: begin
        line_valid = 1'b1;
        if (buf_ready) state_d = last_q ? S_FINISH : S_ISSUE;
      end
      S_FINISH: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Window is registered at capture so line_* stay frozen while the buffer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      base_addr_q <= '0;
      start_q     <= '0;
      end_q       <= '0;
      cur_q       <= '0;
      data_q      <= '0;
      base_q      <= '0;
      bounds_q    <= '0;
      last_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            base_addr_q <= req_base_addr;
            start_q     <= req_start;
            end_q       <= req_end;
            cur_q       <= req_start >> L2E;
          end
        end
        S_WAIT: begin
          if (mem_resp_valid) begin
            data_q   <= mem_resp_data;
            base_q   <= win_base;
            bounds_q <= win_bounds;
            last_q   <= win_last;
          end
        end
        S_PRESENT: begin
          if (buf_ready) begin
            last_q <= 1'b0;
            if (!last_q) cur_q <= cur_q + IDX_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_rd_addr = base_addr_q + (ADDR_WIDTH'(cur_q) << L2LB);
    line_data   = data_q;
    line_base   = base_q;
    line_bounds = bounds_q;
    line_last   = last_q;
  end

endmodule
